// File: rtl/nvdla_pdp_rdma_reg_group_ctrl_if.sv
// Register-access and group-handshake bundle between software/datapath and the PDP RDMA group controller.
// master drives offsets, write strobes, consumer index and per-group pulses; slave returns read data and state.
interface nvdla_pdp_rdma_reg_group_ctrl_if #(
    parameter int NUM_GROUPS = 2,
    parameter int GRP_W      = 1
);
    logic [11:0]             reg_offset;
    logic [31:0]             reg_wr_data;
    logic                    reg_wr_en;
    logic [31:0]             reg_rd_data;
    logic [GRP_W-1:0]        consumer;
    logic [NUM_GROUPS-1:0]   op_en_set;
    logic [NUM_GROUPS-1:0]   op_done;
    logic [GRP_W-1:0]        producer;
    logic [2*NUM_GROUPS-1:0] grp_status;

    modport master (
        output reg_offset, reg_wr_data, reg_wr_en, consumer, op_en_set, op_done,
        input  reg_rd_data, producer, grp_status
    );

    modport slave (
        input  reg_offset, reg_wr_data, reg_wr_en, consumer, op_en_set, op_done,
        output reg_rd_data, producer, grp_status
    );
endinterface

// File: rtl/nvdla_pdp_rdma_reg_group_ctrl.sv
// Purpose: single-register-space ping-pong group controller (producer pointer, per-group FSM, bad-write counter).
// Latency: reads combinational; writes and group transitions visible one cycle after the triggering input.
// Backpressure: none; every write strobe and group pulse is absorbed in the cycle it is presented.
module nvdla_pdp_rdma_reg_group_ctrl #(
    parameter int NUM_GROUPS = 2,
    parameter int GRP_W      = 1
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    nvdla_pdp_rdma_reg_group_ctrl_if.slave bus
);

    localparam logic [11:0] OFF_STATUS  = 12'h000;
    localparam logic [11:0] OFF_POINTER = 12'h004;
    localparam logic [11:0] OFF_ERR     = 12'h008;

    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_PENDING = 2'd1,
        GRP_RUNNING = 2'd2
    } grp_state_e;

    grp_state_e       grp_state_q [NUM_GROUPS];
    grp_state_e       grp_state_d [NUM_GROUPS];
    logic [GRP_W-1:0] producer_q, producer_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [31:0]      status_word;
    logic [31:0]      pointer_word;
    logic             unused_wr_bits;

    assign unused_wr_bits = ^bus.reg_wr_data[31:GRP_W];

    // Anything other than the pointer or the error register counts as a bad write.
    always_comb begin
        producer_d = producer_q;
        err_cnt_d  = err_cnt_q;
        if (bus.reg_wr_en) begin
            case (bus.reg_offset)
                OFF_POINTER: producer_d = bus.reg_wr_data[GRP_W-1:0];
                OFF_ERR:     err_cnt_d  = 8'd0;
                default: begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_state_d[g] = grp_state_q[g];
            case (grp_state_q[g])
                GRP_IDLE: begin
                    if (bus.op_en_set[g]) grp_state_d[g] = GRP_PENDING;
                end
                GRP_PENDING: begin
                    if ((bus.consumer == GRP_W'(g)) && !bus.op_done[g]) grp_state_d[g] = GRP_RUNNING;
                end
                GRP_RUNNING: begin
                    // A re-enable landing with done keeps the group armed rather than idling it.
                    if (bus.op_done[g]) grp_state_d[g] = bus.op_en_set[g] ? GRP_PENDING : GRP_IDLE;
                end
                default: grp_state_d[g] = GRP_IDLE;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            producer_q <= '0;
            err_cnt_q  <= 8'd0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                grp_state_q[g] <= GRP_IDLE;
            end
        end else begin
            producer_q <= producer_d;
            err_cnt_q  <= err_cnt_d;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                grp_state_q[g] <= grp_state_d[g];
            end
        end
    end

    always_comb begin
        bus.grp_status = '0;
        status_word    = 32'd0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            bus.grp_status[2*g +: 2] = grp_state_q[g];
            status_word[8*g +: 2]    = grp_state_q[g];
        end
        pointer_word              = 32'd0;
        pointer_word[GRP_W-1:0]   = producer_q;
        pointer_word[16 +: GRP_W] = bus.consumer;
        case (bus.reg_offset)
            OFF_STATUS:  bus.reg_rd_data = status_word;
            OFF_POINTER: bus.reg_rd_data = pointer_word;
            OFF_ERR:     bus.reg_rd_data = {24'd0, err_cnt_q};
            default:     bus.reg_rd_data = 32'd0;
        endcase
    end

    assign bus.producer = producer_q;

endmodule

// File: tb/tb_nvdla_pdp_rdma_reg_group_ctrl.sv
// Bench for the PDP RDMA group controller: directed scenarios on 2- and 4-group instances,
// plus a randomized run of the 4-group instance against a rule-level reference model.
module tb_nvdla_pdp_rdma_reg_group_ctrl;

    localparam int IDLE = 0;
    localparam int PEND = 1;
    localparam int RUN  = 2;

    logic clk = 1'b0;
    logic rstn;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    nvdla_pdp_rdma_reg_group_ctrl_if #(.NUM_GROUPS(2), .GRP_W(1)) if2 ();
    nvdla_pdp_rdma_reg_group_ctrl_if #(.NUM_GROUPS(4), .GRP_W(2)) if4 ();

    nvdla_pdp_rdma_reg_group_ctrl #(.NUM_GROUPS(2), .GRP_W(1)) dut2 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (if2.slave)
    );

    nvdla_pdp_rdma_reg_group_ctrl #(.NUM_GROUPS(4), .GRP_W(2)) dut4 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (if4.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if2.reg_offset = 12'h0; if2.reg_wr_data = 32'h0; if2.reg_wr_en = 1'b0;
        if2.consumer = '0; if2.op_en_set = '0; if2.op_done = '0;
        if4.reg_offset = 12'h0; if4.reg_wr_data = 32'h0; if4.reg_wr_en = 1'b0;
        if4.consumer = '0; if4.op_en_set = '0; if4.op_done = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic wr2(input logic [11:0] off, input logic [31:0] dat);
        if2.reg_offset  = off;
        if2.reg_wr_data = dat;
        if2.reg_wr_en   = 1'b1;
        tick();
        if2.reg_wr_en   = 1'b0;
    endtask

    task automatic rd2(input logic [11:0] off, output logic [31:0] dat);
        if2.reg_offset = off;
        #1;
        dat = if2.reg_rd_data;
    endtask

    task automatic rd4(input logic [11:0] off, output logic [31:0] dat);
        if4.reg_offset = off;
        #1;
        dat = if4.reg_rd_data;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        idle_inputs();
        rstn = 1'b0;
        #1;
        vec_cnt++; if (if2.producer !== 1'b0) begin err_cnt++; $display("FAIL reset_producer: got %h want 0", if2.producer); end
        vec_cnt++; if (if2.grp_status !== 4'h0) begin err_cnt++; $display("FAIL reset_grp_status: got %h want 0", if2.grp_status); end
        vec_cnt++; if (if4.grp_status !== 8'h0) begin err_cnt++; $display("FAIL reset_grp_status4: got %h want 0", if4.grp_status); end
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL reset_s_status: got %h want 0", r); end
        rd2(12'h004, r);
        vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL reset_s_pointer: got %h want 0", r); end
        rd2(12'h008, r);
        vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL reset_s_err: got %h want 0", r); end
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_pointer();
        logic [31:0] r;
        wr2(12'h004, 32'hFFFF_FFFF);
        vec_cnt++; if (if2.producer !== 1'b1) begin err_cnt++; $display("FAIL ptr_first_write: got %h want 1", if2.producer); end
        if2.consumer = 1'b1;
        rd2(12'h004, r);
        vec_cnt++; if (r !== 32'h0001_0001) begin err_cnt++; $display("FAIL ptr_read: got %h want 00010001", r); end
        wr2(12'h004, 32'hFFFF_FFFE);
        vec_cnt++; if (if2.producer !== 1'b0) begin err_cnt++; $display("FAIL ptr_upper_ignored: got %h want 0", if2.producer); end
        rd2(12'h004, r);
        vec_cnt++; if (r !== 32'h0001_0000) begin err_cnt++; $display("FAIL ptr_read2: got %h want 00010000", r); end
        wr2(12'h004, 32'h0000_0001);
        if2.consumer = 1'b0;
    endtask

    task automatic test_fsm();
        logic [31:0] r;
        if2.op_done = 2'b01;
        tick();
        if2.op_done = 2'b00;
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL fsm_done_in_idle: got %h want 0", r); end
        if2.consumer = 1'b1; if2.op_en_set = 2'b01;
        tick();
        if2.op_en_set = 2'b00;
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0000_0001) begin err_cnt++; $display("FAIL fsm_pending: got %h want 00000001", r); end
        if2.consumer = 1'b0; if2.op_done = 2'b01;
        tick();
        if2.op_done = 2'b00;
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0000_0001) begin err_cnt++; $display("FAIL fsm_pending_done_hold: got %h want 00000001", r); end
        tick();
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0000_0002) begin err_cnt++; $display("FAIL fsm_running: got %h want 00000002", r); end
        if2.op_en_set = 2'b01;
        tick();
        if2.op_en_set = 2'b00;
        vec_cnt++; if (if2.grp_status !== 4'b0010) begin err_cnt++; $display("FAIL fsm_en_in_running: got %b want 0010", if2.grp_status); end
        if2.op_done = 2'b01;
        tick();
        if2.op_done = 2'b00;
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL fsm_done_to_idle: got %h want 0", r); end
        if2.consumer = 1'b1; if2.op_en_set = 2'b11;
        tick();
        if2.op_en_set = 2'b00;
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0000_0101) begin err_cnt++; $display("FAIL fsm_both_pending: got %h want 00000101", r); end
        tick();
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0000_0201) begin err_cnt++; $display("FAIL fsm_g1_running: got %h want 00000201", r); end
        if2.consumer = 1'b0; if2.op_done = 2'b10;
        tick();
        if2.op_done = 2'b00;
        rd2(12'h000, r);
        vec_cnt++; if (r !== 32'h0000_0002) begin err_cnt++; $display("FAIL fsm_independent: got %h want 00000002", r); end
        if2.op_done = 2'b01;
        tick();
        if2.op_done = 2'b00;
    endtask

    task automatic test_rearm();
        if2.consumer = 1'b0; if2.op_en_set = 2'b01;
        tick();
        if2.op_en_set = 2'b00;
        tick();
        vec_cnt++; if (if2.grp_status[1:0] !== 2'd2) begin err_cnt++; $display("FAIL rearm_setup: got %h want 2", if2.grp_status[1:0]); end
        if2.op_en_set = 2'b01; if2.op_done = 2'b01;
        tick();
        if2.op_en_set = 2'b00; if2.op_done = 2'b00;
        vec_cnt++; if (if2.grp_status[1:0] !== 2'd1) begin err_cnt++; $display("FAIL rearm_wins: got %h want 1", if2.grp_status[1:0]); end
        tick();
        if2.op_done = 2'b01;
        tick();
        if2.op_done = 2'b00;
        vec_cnt++; if (if2.grp_status !== 4'h0) begin err_cnt++; $display("FAIL rearm_cleanup: got %h want 0", if2.grp_status); end
    endtask

    task automatic test_err();
        logic [31:0] r;
        for (int i = 0; i < 300; i++) begin
            wr2((i % 2) ? 12'h00C : 12'h000, $urandom);
            if (i == 9) begin
                rd2(12'h008, r);
                vec_cnt++; if (r !== 32'd10) begin err_cnt++; $display("FAIL err_count10: got %h want 0000000a", r); end
            end
            vec_cnt++; if (if2.producer !== 1'b1) begin err_cnt++; $display("FAIL err_producer_kept: iter %0d got %h want 1", i, if2.producer); end
        end
        rd2(12'h008, r);
        vec_cnt++; if (r !== 32'h0000_00FF) begin err_cnt++; $display("FAIL err_saturate: got %h want 000000ff", r); end
        vec_cnt++; if (if2.grp_status !== 4'h0) begin err_cnt++; $display("FAIL err_status_untouched: got %h want 0", if2.grp_status); end
        wr2(12'h008, 32'h1234_5678);
        rd2(12'h008, r);
        vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL err_clear: got %h want 0", r); end
        vec_cnt++; if (if2.producer !== 1'b1) begin err_cnt++; $display("FAIL err_producer_after_clear: got %h want 1", if2.producer); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        wr2(12'h004, 32'h1);
        for (int i = 0; i < 5; i++) wr2(12'h010, 32'h0);
        if2.consumer = 1'b0; if2.op_en_set = 2'b01;
        tick();
        if2.op_en_set = 2'b00;
        tick();
        rd2(12'h008, r);
        vec_cnt++; if (r !== 32'd5 || if2.grp_status[1:0] !== 2'd2) begin err_cnt++; $display("FAIL arst_setup: err %h st %h want 5 2", r, if2.grp_status[1:0]); end
        if2.reg_offset = 12'h004; if2.reg_wr_data = 32'h1; if2.reg_wr_en = 1'b1;
        if2.op_en_set = 2'b01; if2.op_done = 2'b01;
        #1;
        rstn = 1'b0;
        #1;
        vec_cnt++; if (if2.producer !== 1'b0) begin err_cnt++; $display("FAIL arst_producer: got %h want 0", if2.producer); end
        vec_cnt++; if (if2.grp_status !== 4'h0) begin err_cnt++; $display("FAIL arst_status: got %h want 0", if2.grp_status); end
        if2.reg_wr_en = 1'b0;
        rd2(12'h008, r);
        vec_cnt++; if (r !== 32'h0) begin err_cnt++; $display("FAIL arst_err: got %h want 0", r); end
        if2.reg_wr_en = 1'b1; if2.reg_offset = 12'h004;
        tick();
        vec_cnt++; if (if2.producer !== 1'b0 || if2.grp_status !== 4'h0) begin err_cnt++; $display("FAIL arst_hold: prod %h st %h want 0 0", if2.producer, if2.grp_status); end
        if2.op_en_set = 2'b00; if2.op_done = 2'b00;
        rstn = 1'b1;
        tick();
        if2.reg_wr_en = 1'b0;
        vec_cnt++; if (if2.producer !== 1'b1) begin err_cnt++; $display("FAIL arst_first_write: got %h want 1", if2.producer); end
    endtask

    task automatic test_four_groups();
        logic [31:0] r;
        do_reset();
        if4.consumer = 2'd3; if4.op_en_set = 4'b1010;
        tick();
        if4.op_en_set = 4'b0000;
        rd4(12'h000, r);
        vec_cnt++; if (r !== 32'h0100_0100) begin err_cnt++; $display("FAIL g4_pending: got %h want 01000100", r); end
        tick();
        rd4(12'h000, r);
        vec_cnt++; if (r !== 32'h0200_0100) begin err_cnt++; $display("FAIL g4_status: got %h want 02000100", r); end
        vec_cnt++; if (if4.grp_status !== 8'b10_00_01_00) begin err_cnt++; $display("FAIL g4_grp_status: got %b want 10000100", if4.grp_status); end
        rd4(12'h004, r);
        vec_cnt++; if (r !== 32'h0003_0000) begin err_cnt++; $display("FAIL g4_consumer_field: got %h want 00030000", r); end
        if4.reg_offset = 12'h004; if4.reg_wr_data = 32'hFFFF_FFFE; if4.reg_wr_en = 1'b1;
        tick();
        if4.reg_wr_en = 1'b0;
        rd4(12'h004, r);
        vec_cnt++; if (r !== 32'h0003_0002) begin err_cnt++; $display("FAIL g4_pointer: got %h want 00030002", r); end
    endtask

    task automatic test_random();
        int          st [4];
        int          nst [4];
        int          prod;
        int          errc;
        int          en_v, done_v, cons_v, off_v;
        bit          wr_v;
        logic [31:0] dat_v;
        logic [31:0] exp_rd;
        logic [7:0]  exp_st;
        int          offs [6];
        offs = '{0, 4, 8, 12, 16, 4092};
        do_reset();
        for (int g = 0; g < 4; g++) st[g] = IDLE;
        prod = 0;
        errc = 0;
        for (int c = 0; c < 2000; c++) begin
            en_v   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
            done_v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0;
            cons_v = $urandom_range(0, 3);
            wr_v   = ($urandom_range(0, 1) == 1);
            off_v  = offs[$urandom_range(0, 5)];
            dat_v  = $urandom;
            if4.op_en_set = 4'(en_v); if4.op_done = 4'(done_v); if4.consumer = 2'(cons_v);
            if4.reg_wr_en = wr_v; if4.reg_offset = 12'(off_v); if4.reg_wr_data = dat_v;
            #1;
            exp_rd = 32'h0;
            if (off_v == 0) for (int g = 0; g < 4; g++) exp_rd = exp_rd + (32'(st[g]) << (8 * g));
            else if (off_v == 4) exp_rd = 32'(prod) + (32'(cons_v) << 16);
            else if (off_v == 8) exp_rd = 32'(errc);
            vec_cnt++; if (if4.reg_rd_data !== exp_rd) begin err_cnt++; $display("FAIL rand_read: cyc %0d off %h got %h want %h", c, off_v, if4.reg_rd_data, exp_rd); end
            for (int g = 0; g < 4; g++) begin
                nst[g] = st[g];
                if (st[g] == IDLE && en_v[g]) nst[g] = PEND;
                if (st[g] == PEND && cons_v == g && !done_v[g]) nst[g] = RUN;
                if (st[g] == RUN && done_v[g]) nst[g] = en_v[g] ? PEND : IDLE;
            end
            if (wr_v) begin
                if (off_v == 4) prod = int'(dat_v % 4);
                else if (off_v == 8) errc = 0;
                else if (errc < 255) errc = errc + 1;
            end
            tick();
            st = nst;
            exp_st = 8'h0;
            for (int g = 0; g < 4; g++) exp_st = exp_st + (8'(st[g]) << (2 * g));
            vec_cnt++; if (if4.grp_status !== exp_st) begin err_cnt++; $display("FAIL rand_status: cyc %0d got %b want %b", c, if4.grp_status, exp_st); end
            vec_cnt++; if (if4.producer !== 2'(prod)) begin err_cnt++; $display("FAIL rand_producer: cyc %0d got %h want %h", c, if4.producer, prod); end
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        test_reset();
        test_pointer();
        test_fsm();
        test_rearm();
        test_err();
        test_async_reset();
        test_four_groups();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
